stream_rr_mux: RTL and testbench

STREAM_RR_MUX -- requirements
Module: stream_rr_mux

---
 rtl/stream_rr_mux_arbiter.sv | 39 +++
 rtl/stream_rr_mux.sv | 82 ++++++++
 tb/tb_stream_rr_mux.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_rr_mux_arbiter.sv
// Rotating-priority arbiter: grants the first requester strictly after last_grant,
// wrapping from NUM_ELEM-1 to 0. All grants are zero when enable is low.
module rr_arbiter #(
  parameter int unsigned NUM_ELEM = 7,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [NUM_ELEM-1:0] req,
  input  logic [IDX_W-1:0]    last_grant,
  input  logic                enable,
  output logic [NUM_ELEM-1:0] gnt_onehot,
  output logic [IDX_W-1:0]    gnt_idx
);

  logic             found;
  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets 1..NUM_ELEM so the previous winner is considered last.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    cand_idx   = '0;
    for (int unsigned off = 1; off <= NUM_ELEM; off++) begin
      cand = 32'(last_grant) + off;
      if (cand >= NUM_ELEM) begin
        cand = cand - NUM_ELEM;
      end
      cand_idx = cand[IDX_W-1:0];
      if (enable && !found && req[cand_idx]) begin
        found                = 1'b1;
        gnt_onehot[cand_idx] = 1'b1;
        gnt_idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/stream_rr_mux.sv
// Round-robin N:1 valid/ready stream multiplexer with a single registered
// output slot; sel_o reports which channel produced the current word.
module stream_rr_mux #(
  parameter int unsigned NUM_ELEM   = 7,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [DATA_WIDTH-1:0] data_i [NUM_ELEM],
  input  logic [NUM_ELEM-1:0]   valid_i,
  output logic [NUM_ELEM-1:0]   ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [((NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1)-1:0] sel_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned SEL_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEL_W-1:0]      last_q, last_d;

  logic                  slot_free;
  logic                  arb_en;
  logic                  in_xfer;
  logic [NUM_ELEM-1:0]   gnt_onehot;
  logic [SEL_W-1:0]      gnt_idx;

  // Gating with arst_i keeps every ready_o low for the whole reset pulse.
  assign slot_free = ~valid_q | ready_i;
  assign arb_en    = slot_free & ~arst_i;

  rr_arbiter #(
    .NUM_ELEM (NUM_ELEM),
    .IDX_W    (SEL_W)
  ) u_arb (
    .req        (valid_i),
    .last_grant (last_q),
    .enable     (arb_en),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  assign ready_o = gnt_onehot;
  assign in_xfer = |(valid_i & gnt_onehot);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = data_i[gnt_idx];
      sel_d   = gnt_idx;
      last_d  = gnt_idx;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_ELEM - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_stream_rr_mux.sv
// Directed and scoreboarded checks for stream_rr_mux with 7 channels of 8 bits.
module tb_stream_rr_mux;

  localparam int N = 7;

  logic       clk_i;
  logic       arst_i;
  logic [7:0] data_i [N];
  logic [6:0] valid_i;
  logic [6:0] ready_o;
  logic [7:0] data_o;
  logic [2:0] sel_o;
  logic       valid_o;
  logic       ready_i;

  int total = 0;
  int bad   = 0;

  stream_rr_mux #(
    .NUM_ELEM   (N),
    .DATA_WIDTH (8)
  ) dut (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .sel_o   (sel_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    arst_i  = 1'b1;
    valid_i = '0;
    ready_i = 1'b0;
    #2;
    arst_i  = 1'b0;
  endtask

  task automatic test_reset();
    arst_i  = 1'b1;
    valid_i = '1;
    ready_i = 1'b1;
    for (int k = 0; k < N; k++) data_i[k] = 8'hF0 + 8'(k);
    tick();
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", data_o); end
    total++; if (sel_o !== 3'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", sel_o); end
    total++; if (ready_o !== 7'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0000000", ready_o); end
    @(negedge clk_i);
    arst_i  = 1'b0;
    valid_i = '0;
  endtask

  task automatic test_reset_priority();
    int e;
    reset_dut();
    for (int k = 0; k < N; k++) data_i[k] = 8'h20 + 8'(k);
    valid_i = '1;
    ready_i = 1'b1;
    #1;
    total++; if (ready_o !== 7'b0000001) begin bad++; $display("FAIL prio_ready0 got=%b exp=0000001", ready_o); end
    for (int i = 0; i < 8; i++) begin
      tick();
      e = i % N;
      total++; if (sel_o !== 3'(e)) begin bad++; $display("FAIL prio_sel[%0d] got=%0d exp=%0d", i, sel_o, e); end
      total++; if (data_o !== 8'h20 + 8'(e)) begin bad++; $display("FAIL prio_data[%0d] got=%h exp=%h", i, data_o, 8'h20 + 8'(e)); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL prio_valid[%0d] got=%b exp=1", i, valid_o); end
      total++; if (ready_o !== 7'(1 << ((e + 1) % N))) begin bad++; $display("FAIL prio_ready[%0d] got=%b exp=%b", i, ready_o, 7'(1 << ((e + 1) % N))); end
    end
    valid_i = '0;
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL prio_drain got=%b exp=0", valid_o); end
  endtask

  task automatic test_wrap();
    int seq [3];
    seq = '{0, 2, 0};
    reset_dut();
    for (int k = 0; k < N; k++) data_i[k] = 8'h30 + 8'(k);
    valid_i = 7'b0100000;
    ready_i = 1'b1;
    tick();
    total++; if (sel_o !== 3'd5) begin bad++; $display("FAIL wrap_setup got=%0d exp=5", sel_o); end
    valid_i = 7'b0000101;
    #1;
    total++; if (ready_o !== 7'b0000001) begin bad++; $display("FAIL wrap_ready got=%b exp=0000001", ready_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (sel_o !== 3'(seq[i]) || data_o !== 8'h30 + 8'(seq[i])) begin
        bad++; $display("FAIL wrap_grant[%0d] got sel=%0d data=%h exp sel=%0d", i, sel_o, data_o, seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    for (int k = 0; k < N; k++) data_i[k] = 8'h40 + 8'(k);
    data_i[3] = 8'hA5;
    valid_i   = 7'b0001000;
    ready_i   = 1'b0;
    tick();
    valid_i = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (data_o !== 8'hA5 || sel_o !== 3'd3 || valid_o !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got data=%h sel=%0d valid=%b exp A5/3/1", i, data_o, sel_o, valid_o);
      end
      total++; if (ready_o !== 7'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000000", i, ready_o); end
      tick();
    end
    ready_i = 1'b1;
    #1;
    total++; if (ready_o !== 7'b0010000) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010000", ready_o); end
    tick();
    total++; if (sel_o !== 3'd4 || data_o !== 8'h44 || valid_o !== 1'b1) begin
      bad++; $display("FAIL bp_next got sel=%0d data=%h valid=%b exp 4/44/1", sel_o, data_o, valid_o);
    end
  endtask

  task automatic test_single();
    reset_dut();
    for (int k = 0; k < N; k++) data_i[k] = 8'h00;
    valid_i = 7'b0010000;
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i[4] = 8'h10 + 8'(i);
      #1;
      total++; if (ready_o !== 7'b0010000) begin bad++; $display("FAIL single_ready[%0d] got=%b exp=0010000", i, ready_o); end
      tick();
      total++; if (data_o !== 8'h10 + 8'(i) || sel_o !== 3'd4 || valid_o !== 1'b1) begin
        bad++; $display("FAIL single_out[%0d] got data=%h sel=%0d valid=%b exp %h/4/1", i, data_o, sel_o, valid_o, 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int k = 0; k < N; k++) data_i[k] = 8'h50 + 8'(k);
    valid_i = '1;
    ready_i = 1'b1;
    tick();
    tick();
    tick();
    ready_i = 1'b0;
    #1;
    total++; if (valid_o !== 1'b1 || sel_o !== 3'd2) begin bad++; $display("FAIL mid_pre got valid=%b sel=%0d exp 1/2", valid_o, sel_o); end
    @(negedge clk_i);
    arst_i = 1'b1;
    #1;
    total++; if (valid_o !== 1'b0 || data_o !== 8'h00 || sel_o !== 3'd0) begin
      bad++; $display("FAIL mid_rst_out got valid=%b data=%h sel=%0d exp 0/00/0", valid_o, data_o, sel_o);
    end
    total++; if (ready_o !== 7'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000000", ready_o); end
    #1;
    arst_i = 1'b0;
    #1;
    total++; if (ready_o !== 7'b0000001) begin bad++; $display("FAIL mid_release_ready got=%b exp=0000001", ready_o); end
    tick();
    total++; if (sel_o !== 3'd0 || data_o !== 8'h50 || valid_o !== 1'b1) begin
      bad++; $display("FAIL mid_first got sel=%0d data=%h valid=%b exp 0/50/1", sel_o, data_o, valid_o);
    end
    valid_i = '0;
    ready_i = 1'b1;
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL mid_no_repeat got=%b exp=0", valid_o); end
  endtask

  task automatic test_random();
    logic [10:0] q[$];
    logic [10:0] w;
    logic [6:0]  pend;
    logic [6:0]  exp_rdy;
    int          waits [N];
    int          mlast;
    int          g;
    int          c;
    logic        exp_valid;
    reset_dut();
    pend  = '0;
    mlast = N - 1;
    for (int k = 0; k < N; k++) waits[k] = 0;
    @(posedge clk_i);
    #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom % 3 == 0)) begin
          pend[k]   = 1'b1;
          data_i[k] = 8'($urandom);
        end
      end
      valid_i = pend;
      ready_i = ($urandom % 4) != 0;
      #1;
      exp_valid = (q.size() != 0);
      total++; if (valid_o !== exp_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, valid_o, exp_valid); end
      exp_rdy = '0;
      g = -1;
      if ((!exp_valid || ready_i) && (valid_i != 0)) begin
        for (int off = 1; off <= N; off++) begin
          c = (mlast + off) % N;
          if (g < 0 && valid_i[c]) g = c;
        end
        exp_rdy[g] = 1'b1;
      end
      total++; if (ready_o !== exp_rdy) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, ready_o, exp_rdy); end
      if (exp_valid && ready_i) begin
        w = q.pop_front();
        total++; if (data_o !== w[7:0] || sel_o !== w[10:8]) begin
          bad++; $display("FAIL rnd_out[%0d] got data=%h sel=%0d exp data=%h sel=%0d", cyc, data_o, sel_o, w[7:0], w[10:8]);
        end
      end
      if (g >= 0) begin
        q.push_back({3'(g), data_i[g]});
        total++; if (waits[g] > N - 1) begin bad++; $display("FAIL rnd_starve ch=%0d got=%0d exp<=%0d", g, waits[g], N - 1); end
        waits[g] = 0;
        for (int k = 0; k < N; k++) if (k != g && pend[k]) waits[k]++;
        pend[g] = 1'b0;
        mlast   = g;
      end
      tick();
    end
    valid_i = '0;
    ready_i = 1'b1;
    #1;
    if (q.size() != 0) begin
      w = q.pop_front();
      total++; if (data_o !== w[7:0] || sel_o !== w[10:8] || valid_o !== 1'b1) begin
        bad++; $display("FAIL rnd_drain got data=%h sel=%0d valid=%b exp data=%h sel=%0d", data_o, sel_o, valid_o, w[7:0], w[10:8]);
      end
    end
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rnd_empty got=%b exp=0", valid_o); end
  endtask

  initial begin
    arst_i  = 1'b1;
    valid_i = '0;
    ready_i = 1'b0;
    for (int k = 0; k < N; k++) data_i[k] = 8'h00;
    test_reset();
    test_reset_priority();
    test_wrap();
    test_backpressure();
    test_single();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
